// File: rtl/maze_mem_arbiter.sv
// Purpose: round-robin arbiter sharing one single-port maze cell memory between solver (port 0) and playback (port 1), with an atomic lock.
// Latency: grant and memory issue are combinational in the request cycle; read data returns RD_LAT+1 cycles after the grant.
// Backpressure: a requester holds req/qualifiers until its gnt; the lock blocks the other port, and a lock held LOCK_MAX cycles is force-released.
module maze_mem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 1,
    parameter int RD_LAT   = 1,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    // port 0: solver controller
    input  logic              req0,
    input  logic              we0,
    input  logic              lock0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    // port 1: playback/display unit
    input  logic              req1,
    input  logic              we1,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    // memory side
    output logic              mem_cen,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              err_lock
);

    localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_ptr;
    logic               w_ptr_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_err;
    logic               w_err_nxt;
    logic               w_arb0;
    logic               w_arb1;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_mem_wr;
    logic               w_mem_rd;
    logic [ADDR_W-1:0]  w_mem_addr;
    logic [DATA_W-1:0]  w_mem_din;
    logic [ADDR_W-1:0]  r_addr_hold;
    logic [DATA_W-1:0]  r_din_hold;
    logic [RD_LAT-1:0]  r_tag_vld;
    logic [RD_LAT-1:0]  r_tag_id;
    logic               w_ret_vld;
    logic               w_ret_id;
    logic               r_rvalid0;
    logic               r_rvalid1;
    logic [DATA_W-1:0]  r_rdata0;
    logic [DATA_W-1:0]  r_rdata1;

    // Arbitration, lock tracking and next-state decode.
    always_comb begin
        w_arb0      = 1'b0;
        w_arb1      = 1'b0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // On a tie the port that did not win last time goes first.
                if (req0 && req1) begin
                    w_arb0 = r_ptr;
                    w_arb1 = ~r_ptr;
                end else begin
                    w_arb0 = req0;
                    w_arb1 = req1;
                end
                if (w_arb0 && lock0) begin
                    w_state_nxt = ST_LOCK0;
                    w_cnt_nxt   = '0;
                end else if (w_arb1 && lock1) begin
                    w_state_nxt = ST_LOCK1;
                    w_cnt_nxt   = '0;
                end
            end
            ST_LOCK0: begin
                w_arb0    = req0;
                w_cnt_nxt = r_cnt + CNT_W'(1);
                // Granted access without lock, or an idle cycle without lock,
                // both release; since the owner is granted whenever it asks,
                // that collapses to lock0 being low.
                if (!lock0) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_err_nxt   = 1'b1;
                end
            end
            ST_LOCK1: begin
                w_arb1    = req1;
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (!lock1) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_err_nxt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Grants are suppressed while reset is asserted.
    assign w_gnt0 = w_arb0 & rst;
    assign w_gnt1 = w_arb1 & rst;
    assign w_ptr_nxt = w_gnt0 ? 1'b0 : (w_gnt1 ? 1'b1 : r_ptr);

    assign w_mem_wr = (w_gnt0 & we0) | (w_gnt1 & we1);
    assign w_mem_rd = (w_gnt0 & ~we0) | (w_gnt1 & ~we1);

    // Memory address/data mux; holds the last issued value when idle.
    always_comb begin
        w_mem_addr = r_addr_hold;
        w_mem_din  = r_din_hold;
        if (w_gnt0) begin
            w_mem_addr = addr0;
            w_mem_din  = wdata0;
        end else if (w_gnt1) begin
            w_mem_addr = addr1;
            w_mem_din  = wdata1;
        end
    end

    // Arbiter state, round-robin pointer, lock counter and timeout pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= 1'b1;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Remember the last issued address/data for idle cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr_hold <= '0;
            r_din_hold  <= '0;
        end else if (w_gnt0 || w_gnt1) begin
            r_addr_hold <= w_mem_addr;
            r_din_hold  <= w_mem_din;
        end
    end

    // Read tag pipeline: {valid, port id} follows each read through the memory latency.
    if (RD_LAT > 1) begin : g_tag_deep
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_tag_vld <= '0;
                r_tag_id  <= '0;
            end else begin
                r_tag_vld <= {r_tag_vld[RD_LAT-2:0], w_mem_rd};
                r_tag_id  <= {r_tag_id[RD_LAT-2:0], w_gnt1};
            end
        end
    end else begin : g_tag_single
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_tag_vld <= '0;
                r_tag_id  <= '0;
            end else begin
                r_tag_vld <= w_mem_rd;
                r_tag_id  <= w_gnt1;
            end
        end
    end

    assign w_ret_vld = r_tag_vld[RD_LAT-1];
    assign w_ret_id  = r_tag_id[RD_LAT-1];

    // Capture returning read data into the issuing port; rdata holds between returns.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_rvalid0 <= w_ret_vld & ~w_ret_id;
            r_rvalid1 <= w_ret_vld & w_ret_id;
            if (w_ret_vld && !w_ret_id) begin
                r_rdata0 <= mem_dout;
            end
            if (w_ret_vld && w_ret_id) begin
                r_rdata1 <= mem_dout;
            end
        end
    end

    assign gnt0     = w_gnt0;
    assign gnt1     = w_gnt1;
    assign mem_cen  = w_gnt0 | w_gnt1;
    assign mem_wr   = w_mem_wr;
    assign mem_rd   = w_mem_rd;
    assign mem_addr = w_mem_addr;
    assign mem_din  = w_mem_din;
    assign rvalid0  = r_rvalid0;
    assign rvalid1  = r_rvalid1;
    assign rdata0   = r_rdata0;
    assign rdata1   = r_rdata1;
    assign err_lock = r_err;

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Bench for maze_mem_arbiter: directed scenarios plus randomized traffic against a reference model.
// Latency: outputs sampled on the falling edge; inputs driven 1 time unit after the rising edge.
// Backpressure: requesters hold req and qualifiers until granted.
module tb_maze_mem_arbiter;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 1;
    localparam int RD_LAT   = 1;
    localparam int LOCK_MAX = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0, we0, lock0, req1, we1, lock1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1, rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              mem_cen, mem_wr, mem_rd, err_lock;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        int cyc_due;
        bit port;
        bit data;
    } ret_t;

    // Memory: unwritten cells read a fixed address pattern, written cells read back what was written.
    bit mem_seen [256];
    bit mem_val  [256];

    function automatic bit init_bit(logic [7:0] a);
        return a[0] ^ a[3];
    endfunction

    always #5 clk = ~clk;

    // Single-port synchronous memory with one cycle read latency.
    always @(posedge clk) begin
        if (mem_cen && mem_wr) begin
            mem_seen[mem_addr] <= 1'b1;
            mem_val[mem_addr]  <= mem_din[0];
        end
        if (mem_cen && mem_rd) begin
            mem_dout <= mem_seen[mem_addr] ? mem_val[mem_addr] : init_bit(mem_addr);
        end
    end

    maze_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_cen(mem_cen), .mem_wr(mem_wr), .mem_rd(mem_rd),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .err_lock(err_lock)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 0; we0 = 0; lock0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; lock1 = 0; addr1 = '0; wdata1 = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        req0 = 1; req1 = 1;
        tick();
        @(negedge clk);
        n_chk++; if ({gnt0, gnt1} !== 2'b00) $display("FAIL rst_gnt: got %b want 00", {gnt0, gnt1}); else n_pass++;
        n_chk++; if ({mem_cen, mem_wr, mem_rd} !== 3'b000) $display("FAIL rst_mem: got %b want 000", {mem_cen, mem_wr, mem_rd}); else n_pass++;
        n_chk++; if ({rvalid0, rvalid1, rdata0, rdata1, err_lock} !== 5'b0) $display("FAIL rst_out: got %b want 00000", {rvalid0, rvalid1, rdata0, rdata1, err_lock}); else n_pass++;
        tick();
        idle_inputs();
        rst = 1'b1;
    endtask

    task automatic test_single_read();
        req0 = 1; we0 = 0; lock0 = 0; addr0 = 8'h35;
        @(negedge clk);
        n_chk++; if ({gnt0, gnt1} !== 2'b10) $display("FAIL sr_gnt: got %b want 10", {gnt0, gnt1}); else n_pass++;
        n_chk++; if ({mem_cen, mem_rd, mem_wr} !== 3'b110) $display("FAIL sr_strobes: got %b want 110", {mem_cen, mem_rd, mem_wr}); else n_pass++;
        n_chk++; if (mem_addr !== 8'h35) $display("FAIL sr_addr: got %h want 35", mem_addr); else n_pass++;
        tick();
        req0 = 0;
        @(negedge clk);
        n_chk++; if (rvalid0 !== 1'b0) $display("FAIL sr_early: rvalid0 got %b want 0", rvalid0); else n_pass++;
        tick();
        @(negedge clk);
        n_chk++; if ({rvalid0, rdata0, rvalid1} !== 3'b110) $display("FAIL sr_ret: got %b want 110", {rvalid0, rdata0, rvalid1}); else n_pass++;
        tick();
    endtask

    task automatic test_contention();
        int   k0, k1, ngr, cyc;
        bit   g0, g1, ev0, ev1, ed;
        ret_t rq[$];
        ret_t r;
        apply_reset();
        k0 = 0; k1 = 0; ngr = 0;
        for (cyc = 0; cyc < 14; cyc++) begin
            req0 = (k0 < 4); we0 = 0; addr0 = 8'h40 + 8'(k0);
            req1 = (k1 < 4); we1 = 0; addr1 = 8'h80 + 8'(k1);
            @(negedge clk);
            g0 = gnt0; g1 = gnt1;
            if (g0 || g1) begin
                n_chk++;
                if ({g0, g1} !== ((ngr % 2 == 0) ? 2'b10 : 2'b01))
                    $display("FAIL ct_order grant %0d: got %b want port %0d", ngr, {g0, g1}, ngr % 2);
                else n_pass++;
                rq.push_back('{cyc + RD_LAT + 1, g1, init_bit(g1 ? addr1 : addr0)});
                ngr++;
            end
            ev0 = 0; ev1 = 0; ed = 0;
            if (rq.size() > 0 && rq[0].cyc_due == cyc) begin
                r = rq.pop_front();
                if (r.port) ev1 = 1; else ev0 = 1;
                ed = r.data;
            end
            n_chk++; if ({rvalid0, rvalid1} !== {ev0, ev1}) $display("FAIL ct_rvalid cyc %0d: got %b want %b", cyc, {rvalid0, rvalid1}, {ev0, ev1}); else n_pass++;
            if (ev0) begin n_chk++; if (rdata0 !== ed) $display("FAIL ct_rdata0 cyc %0d: got %b want %b", cyc, rdata0, ed); else n_pass++; end
            if (ev1) begin n_chk++; if (rdata1 !== ed) $display("FAIL ct_rdata1 cyc %0d: got %b want %b", cyc, rdata1, ed); else n_pass++; end
            tick();
            if (g0) k0++;
            if (g1) k1++;
        end
        n_chk++; if (ngr != 8 || rq.size() != 0) $display("FAIL ct_count: grants %0d want 8, unreturned %0d want 0", ngr, rq.size()); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_rmw();
        apply_reset();
        req0 = 1; we0 = 0; lock0 = 1; addr0 = 8'h35;
        req1 = 1; we1 = 0; lock1 = 0; addr1 = 8'h11;
        @(negedge clk);
        n_chk++; if ({gnt0, gnt1} !== 2'b10) $display("FAIL rmw_rd: got %b want 10", {gnt0, gnt1}); else n_pass++;
        tick();
        we0 = 1; lock0 = 0; wdata0 = 1'b1;
        @(negedge clk);
        n_chk++; if ({gnt0, gnt1, mem_wr, mem_din} !== 4'b1011) $display("FAIL rmw_wr: got %b want 1011", {gnt0, gnt1, mem_wr, mem_din}); else n_pass++;
        n_chk++; if (mem_addr !== 8'h35) $display("FAIL rmw_addr: got %h want 35", mem_addr); else n_pass++;
        tick();
        req0 = 0; we0 = 0;
        @(negedge clk);
        n_chk++; if ({gnt0, gnt1} !== 2'b01) $display("FAIL rmw_after: got %b want 01", {gnt0, gnt1}); else n_pass++;
        n_chk++; if ({rvalid0, rdata0} !== 2'b11) $display("FAIL rmw_rret: got %b want 11", {rvalid0, rdata0}); else n_pass++;
        tick();
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_lock_timeout();
        int bad;
        apply_reset();
        req0 = 1; we0 = 0; lock0 = 1; addr0 = 8'h01;
        @(negedge clk);
        n_chk++; if (gnt0 !== 1'b1) $display("FAIL lt_lock: gnt0 got %b want 1", gnt0); else n_pass++;
        tick();
        req0 = 0; lock0 = 1;
        req1 = 1; we1 = 0; addr1 = 8'h02;
        bad = 0;
        for (int i = 1; i <= LOCK_MAX; i++) begin
            @(negedge clk);
            n_chk++;
            if ({gnt1, err_lock} !== 2'b00) $display("FAIL lt_hold lock cycle %0d: gnt1,err_lock got %b want 00", i, {gnt1, err_lock});
            else n_pass++;
            tick();
        end
        @(negedge clk);
        n_chk++; if ({err_lock, gnt1, gnt0} !== 3'b110) $display("FAIL lt_expire: err_lock,gnt1,gnt0 got %b want 110", {err_lock, gnt1, gnt0}); else n_pass++;
        tick();
        idle_inputs();
        @(negedge clk);
        n_chk++; if (err_lock !== 1'b0) $display("FAIL lt_pulse: err_lock got %b want 0", err_lock); else n_pass++;
        tick();
        tick();
    endtask

    task automatic test_write_only();
        idle_inputs();
        req1 = 1; we1 = 1; addr1 = 8'h22; wdata1 = 1'b1;
        @(negedge clk);
        n_chk++; if ({gnt1, mem_cen, mem_wr, mem_rd, mem_din} !== 5'b11101) $display("FAIL wo_issue: got %b want 11101", {gnt1, mem_cen, mem_wr, mem_rd, mem_din}); else n_pass++;
        tick();
        idle_inputs();
        @(negedge clk);
        n_chk++; if ({mem_cen, mem_addr} !== {1'b0, 8'h22}) $display("FAIL wo_hold: cen,addr got %b,%h want 0,22", mem_cen, mem_addr); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            n_chk++; if (rvalid1 !== 1'b0) $display("FAIL wo_norv cyc %0d: rvalid1 got %b want 0", i, rvalid1); else n_pass++;
            tick();
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        req0 = 1; we0 = 0; addr0 = 8'h35;
        @(negedge clk);
        n_chk++; if (gnt0 !== 1'b1) $display("FAIL ar_pre: gnt0 got %b want 1", gnt0); else n_pass++;
        tick();
        req0 = 1; req1 = 1; addr1 = 8'h36;
        #2;
        rst = 1'b0;
        #1;
        n_chk++; if ({gnt0, gnt1, mem_cen} !== 3'b000) $display("FAIL ar_gate: gnt0,gnt1,cen got %b want 000", {gnt0, gnt1, mem_cen}); else n_pass++;
        tick();
        n_chk++; if (rvalid0 !== 1'b0) $display("FAIL ar_drop: rvalid0 got %b want 0", rvalid0); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_chk++; if ({gnt0, gnt1, rvalid0} !== 3'b100) $display("FAIL ar_tie: gnt0,gnt1,rvalid0 got %b want 100", {gnt0, gnt1, rvalid0}); else n_pass++;
        tick();
        req0 = 0;
        @(negedge clk);
        n_chk++; if ({gnt1, rvalid0} !== 2'b10) $display("FAIL ar_next: gnt1,rvalid0 got %b want 10", {gnt1, rvalid0}); else n_pass++;
        tick();
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_random();
        int   owner, held, last, g, cyc;
        bit   err_exp, nerr, known, gw, gd, lk, rqo, ev0, ev1, ed, hold0, hold1;
        logic [7:0] ga, la;
        bit   mm [256];
        ret_t rq[$];
        ret_t r;
        apply_reset();
        for (int i = 0; i < 256; i++) mm[i] = mem_seen[i] ? mem_val[i] : init_bit(8'(i));
        owner = -1; held = 0; last = 1; err_exp = 0; known = 0; la = '0; hold0 = 0; hold1 = 0;
        g = -1;
        for (cyc = 0; cyc < 800; cyc++) begin
            if (g == 0 || (!req0 && $urandom_range(0, 9) < 3)) begin
                req0 = ($urandom_range(0, 9) < 6); we0 = 1'($urandom_range(0, 1));
                lock0 = ($urandom_range(0, 9) < 5); addr0 = 8'($urandom_range(0, 255));
                wdata0 = 1'($urandom_range(0, 1));
            end
            if (g == 1 || (!req1 && $urandom_range(0, 9) < 3)) begin
                req1 = ($urandom_range(0, 9) < 6); we1 = 1'b0;
                lock1 = ($urandom_range(0, 9) < 5); addr1 = 8'($urandom_range(0, 255));
                wdata1 = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            // Who should own the memory this cycle.
            g = -1;
            if (owner < 0) begin
                if (req0 && req1) g = (last == 0) ? 1 : 0;
                else if (req0) g = 0;
                else if (req1) g = 1;
            end else if (owner == 0) begin
                if (req0) g = 0;
            end else begin
                if (req1) g = 1;
            end
            n_chk++;
            if ({gnt0, gnt1, mem_cen, err_lock} !== {(g == 0), (g == 1), (g >= 0), err_exp})
                $display("FAIL rnd_ctl cyc %0d: gnt0,gnt1,cen,err got %b want %b", cyc, {gnt0, gnt1, mem_cen, err_lock}, {(g == 0), (g == 1), (g >= 0), err_exp});
            else n_pass++;
            if (g >= 0) begin
                gw = (g == 0) ? we0 : we1;
                ga = (g == 0) ? addr0 : addr1;
                gd = (g == 0) ? wdata0 : wdata1;
                n_chk++;
                if ({mem_wr, mem_rd, mem_addr} !== {gw, ~gw, ga}) $display("FAIL rnd_issue cyc %0d: wr,rd,addr got %b,%b,%h want %b,%b,%h", cyc, mem_wr, mem_rd, mem_addr, gw, ~gw, ga);
                else n_pass++;
                if (gw) begin n_chk++; if (mem_din !== gd) $display("FAIL rnd_din cyc %0d: got %b want %b", cyc, mem_din, gd); else n_pass++; end
            end else if (known) begin
                n_chk++;
                if ({mem_wr, mem_rd, mem_addr} !== {2'b00, la}) $display("FAIL rnd_idle cyc %0d: wr,rd,addr got %b,%b,%h want 0,0,%h", cyc, mem_wr, mem_rd, mem_addr, la);
                else n_pass++;
            end
            ev0 = 0; ev1 = 0;
            if (rq.size() > 0 && rq[0].cyc_due == cyc) begin
                r = rq.pop_front();
                if (r.port) begin ev1 = 1; hold1 = r.data; end
                else begin ev0 = 1; hold0 = r.data; end
            end
            n_chk++;
            if ({rvalid0, rvalid1, rdata0, rdata1} !== {ev0, ev1, hold0, hold1})
                $display("FAIL rnd_ret cyc %0d: rv0,rv1,rd0,rd1 got %b want %b", cyc, {rvalid0, rvalid1, rdata0, rdata1}, {ev0, ev1, hold0, hold1});
            else n_pass++;
            // Advance the model to the next cycle.
            if (g >= 0) begin
                last = g; la = ga; known = 1;
                if (gw) mm[ga] = gd;
                else rq.push_back('{cyc + RD_LAT + 1, (g == 1), mm[ga]});
            end
            nerr = 0;
            if (owner < 0) begin
                if (g == 0 && lock0) begin owner = 0; held = 0; end
                else if (g == 1 && lock1) begin owner = 1; held = 0; end
            end else begin
                lk  = (owner == 0) ? lock0 : lock1;
                rqo = (owner == 0) ? req0 : req1;
                if ((g == owner && !lk) || (!rqo && !lk)) owner = -1;
                else if (held == LOCK_MAX - 1) begin owner = -1; nerr = 1; end
                else held++;
            end
            err_exp = nerr;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        test_reset();
        test_single_read();
        test_contention();
        test_rmw();
        test_lock_timeout();
        test_write_only();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/maze_mem_arbiter.md
Name: maze_mem_arbiter

Overview:
- Shares the single-port maze cell memory between two requesters:
  - port 0: the rat solver controller, which does visit-mark reads and writes;
  - port 1: the path playback/display unit, which only reads.
- Issues at most one memory access per cycle, using round-robin arbitration.
- A lock lets one owner run an atomic read-modify-write sequence without the other port interleaving.
- Returns read data to the issuing port after a fixed memory latency.

Parameters:
- ADDR_W, 8, cell address width ({X,Y}, 4+4 bits).
- DATA_W, 1, cell data width.
- RD_LAT, 1, memory read latency in cycles (≥1).
- LOCK_MAX, 16, maximum number of cycles a lock may be held before forced release.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req0  in  1  port 0 access request, held until granted.
- we0  in  1  port 0 access type: 1 write, 0 read.
- lock0  in  1  port 0 keeps ownership after this access.
- addr0  in  ADDR_W  port 0 cell address.
- wdata0  in  DATA_W  port 0 write data.
- gnt0  out  1  port 0 access issued this cycle.
- rvalid0  out  1  port 0 read data valid (1-cycle pulse).
- rdata0  out  DATA_W  port 0 read data.
- req1, we1, lock1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1.
- mem_cen  out  1  memory chip enable.
- mem_wr  out  1  memory write strobe.
- mem_rd  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_din  out  DATA_W  memory write data.
- mem_dout  in  DATA_W  memory read data, valid RD_LAT cycles after mem_rd.
- err_lock  out  1  pulse: lock forced released by timeout.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, last-grant pointer ptr=1 (so port 0 wins the first tie), lock counter=0, read tag pipeline cleared.
  - rvalid0/1=0, rdata0/1=0, err_lock=0.
  - gnt0/1, mem_cen, mem_wr and mem_rd are forced to 0 while rst=0.
- Grant generation:
  - gnt0/gnt1 are combinational from req, state and ptr.
  - At most one grant is high in any cycle.
  - A grant is the issue cycle: in the same cycle mem_cen=1, mem_wr=we_i, mem_rd=~we_i, mem_addr=addr_i, mem_din=wdata_i.
  - With no grant, mem_cen=mem_wr=mem_rd=0, and mem_addr/mem_din hold their last driven value.
- Requester rule:
  - req_i and its qualifiers stay stable until the cycle gnt_i=1.
  - A new request may follow back-to-back in the next cycle.
- State IDLE:
  - Only one port requesting: that port is granted.
  - Both requesting: the port ≠ ptr is granted.
  - ptr updates to the granted port at the clock edge.
  - If the granted access has lock_i=1: go to LOCK_i, counter=0.
- State LOCK_i:
  - The other port is never granted; req_i is granted whenever asserted.
  - counter increments every cycle.
  - Exit to IDLE at the edge after either of these:
    - a granted access with lock_i=0 (normal release; that access still completes);
    - a cycle with req_i=0 and lock_i=0.
  - If counter reaches LOCK_MAX-1 while still in LOCK_i: go to IDLE and pulse err_lock for 1 cycle. Any access granted in that same cycle still issues.
- Read return:
  - A tag pipeline RD_LAT deep carries {valid, port id} for each issued read.
  - When the tag emerges, rdata_port is registered from mem_dout and rvalid_port pulses.
  - Total latency is RD_LAT+1 cycles from grant to rvalid.
  - rdata_i holds its value until the next read return to that port.
  - Writes produce no rvalid.
- Simultaneous events:
  - Lock release and the other port's request in the same cycle: the other port is granted in the next cycle, not the same one.
  - The read pipeline is independent of arbitration state. Outstanding reads still return after a lock exit or timeout.
- Reset mid-operation: pending read returns are discarded and no rvalid is produced after reset.

Test Plan:
- Single read: req0=1, we0=0, addr0=8'h35, memory cell=1 → gnt0 in the same cycle with mem_rd=1 and mem_addr=8'h35; rvalid0=1 and rdata0=1 two cycles later (RD_LAT=1).
- Contention: req0 and req1 both held for 4 reads each → grants alternate 0,1,0,1,…, starting with port 0 after reset; all 8 rvalids are routed to the correct port.
- Atomic RMW: port 0 issues read with lock0=1, then write 8'h35 with data 1 and lock0=0, while req1 is held → gnt1 stays low until the cycle after the write grant; port 1 is then granted.
- Lock timeout: port 0 locks, then holds req0=0 with lock0=1 → err_lock pulses once after 16 cycles in LOCK_0; port 1 is granted in the following cycle.
- Write only: req1=1, we1=1 → mem_wr=1, mem_rd=0, and rvalid1 never asserts.
- Async reset: drop rst between a read grant and its return → rvalid stays 0, gnt0/gnt1/mem_cen go to 0 immediately, and the first grant after reset goes to port 0 on a tie.
